// File: rtl/fcvt_s_wu_if.sv
// Handshake bundle for the unsigned-int -> single-precision converter.
//   valid_input  : a/rm valid (master -> slave)
//   a            : unsigned integer operand
//   rm           : RISC-V rounding mode
//   busy         : converter is not in IDLE
//   valid_output : one-cycle pulse, y/nx valid
//   y            : IEEE-754 single result
//   nx           : inexact flag
interface fcvt_s_wu_if #(
    parameter int WIDTH = 32
);
    logic             valid_input;
    logic [WIDTH-1:0] a;
    logic [2:0]       rm;
    logic             busy;
    logic             valid_output;
    logic [WIDTH-1:0] y;
    logic             nx;

    modport master (
        output valid_input, a, rm,
        input  busy, valid_output, y, nx
    );

    modport slave (
        input  valid_input, a, rm,
        output busy, valid_output, y, nx
    );
endinterface

// File: rtl/fcvt_s_wu.sv
// Multi-cycle converter: 32-bit unsigned integer -> IEEE-754 single
// (RISC-V FCVT.S.WU). One op every five cycles, one-shot valid handshake.
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : slave side of fcvt_s_wu_if (valid_input/a/rm in,
//           busy/valid_output/y/nx out)
//
// state | meaning
// ------+---------------------------------------------------------
// IDLE  | waiting for valid_input; latches a/rm on accept
// NORM  | find leading one, normalise to 24 bits, derive guard/sticky
// ROUND | apply rounding increment, fix up exponent on carry-out
// PACK  | assemble y/nx
// DONE  | raise valid_output for one cycle
module fcvt_s_wu #(
    parameter int WIDTH = 32
) (
    input  logic        clk,
    input  logic        rst_n,
    fcvt_s_wu_if.slave  bus
);
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        NORM  = 3'd1,
        ROUND = 3'd2,
        PACK  = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t state, state_next;

    logic [WIDTH-1:0] a_r;
    logic [2:0]       rm_r;
    logic [23:0]      sig_r;
    logic [7:0]       exp_r;
    logic             g_r, s_r, zero_r, nx_r;
    logic [22:0]      mant_r;

    logic [4:0]       p;
    logic [4:0]       sh;
    logic [WIDTH-1:0] mask;
    logic [23:0]      sig_n;
    logic             g_n, s_n;
    logic             inc;
    logic             carry;
    logic [22:0]      mant_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.valid_input) state_next = NORM;
            NORM:    state_next = ROUND;
            ROUND:   state_next = PACK;
            PACK:    state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign bus.busy = (state != IDLE);

    // Leading-one position and normalisation. Values wider than 24 bits
    // shift right; the first dropped bit is the guard, the rest fold into sticky.
    always_comb begin
        p = '0;
        for (int i = 0; i < WIDTH; i++)
            if (a_r[i]) p = 5'(i);
        sh    = '0;
        mask  = '0;
        g_n   = 1'b0;
        s_n   = 1'b0;
        sig_n = '0;
        if (p <= 5'd23) begin
            sh    = 5'd23 - p;
            sig_n = 24'(a_r << sh);
        end else begin
            sh    = p - 5'd23;
            sig_n = 24'(a_r >> sh);
            g_n   = a_r[sh - 5'd1];
            mask  = (WIDTH'(1) << (sh - 5'd1)) - WIDTH'(1);
            s_n   = |(a_r & mask);
        end
    end

    // Operand is never negative, so RDN behaves like RTZ and RUP like
    // "round away"; unused encodings fall back to RNE.
    always_comb begin
        case (rm_r)
            3'b001, 3'b010: inc = 1'b0;
            3'b011:         inc = g_r | s_r;
            3'b100:         inc = g_r;
            default:        inc = g_r & (s_r | sig_r[0]);
        endcase
        // Hidden bit is always set for non-zero input, so an all-ones
        // significand plus the increment overflows into bit 24.
        carry  = inc & (&sig_r);
        mant_n = sig_r[22:0] + 23'(inc);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_r              <= '0;
            rm_r             <= '0;
            sig_r            <= '0;
            exp_r            <= '0;
            g_r              <= 1'b0;
            s_r              <= 1'b0;
            zero_r           <= 1'b0;
            nx_r             <= 1'b0;
            mant_r           <= '0;
            bus.y            <= '0;
            bus.nx           <= 1'b0;
            bus.valid_output <= 1'b0;
        end else begin
            bus.valid_output <= (state == DONE);
            case (state)
                IDLE: begin
                    if (bus.valid_input) begin
                        a_r  <= bus.a;
                        rm_r <= bus.rm;
                    end
                end
                NORM: begin
                    sig_r  <= sig_n;
                    exp_r  <= 8'd127 + {3'b000, p};
                    g_r    <= g_n;
                    s_r    <= s_n;
                    zero_r <= (a_r == '0);
                end
                ROUND: begin
                    mant_r <= carry ? 23'd0 : mant_n;
                    exp_r  <= carry ? exp_r + 8'd1 : exp_r;
                    nx_r   <= g_r | s_r;
                end
                PACK: begin
                    bus.y  <= zero_r ? '0 : {1'b0, exp_r, mant_r};
                    bus.nx <= zero_r ? 1'b0 : nx_r;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_fcvt_s_wu.sv
module tb_fcvt_s_wu;
    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    fcvt_s_wu_if #(.WIDTH(32)) bus ();

    fcvt_s_wu #(.WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [2:0]  rm;
        logic [31:0] y;
        logic        nx;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference: exact integer arithmetic on the value, rounding decided by
    // comparing the discarded remainder against one half ulp.
    function automatic void ref_model(input logic [31:0] av, input logic [2:0] rv,
                                      output logic [31:0] yv, output logic nxv);
        longint unsigned v, q, r, half;
        int e;
        bit inc;
        v = 64'(av);
        if (av == 0) begin
            yv = 32'h0; nxv = 1'b0;
            return;
        end
        e = 0;
        while ((v >> (e + 1)) != 0) e++;
        if (e > 23) begin
            q    = v >> (e - 23);
            r    = v - (q << (e - 23));
            half = 64'd1 << (e - 24);
        end else begin
            q    = v << (23 - e);
            r    = 0;
            half = 1;
        end
        case (rv)
            3'd1, 3'd2: inc = 1'b0;
            3'd3:       inc = (r != 0);
            3'd4:       inc = (r >= half);
            default:    inc = (r > half) || ((r == half) && q[0]);
        endcase
        q = q + 64'(inc);
        if (q == (64'd1 << 24)) begin
            q = q >> 1;
            e++;
        end
        yv  = {1'b0, 8'(e + 127), q[22:0]};
        nxv = (r != 0);
    endfunction

    task automatic run_op(input logic [31:0] av, input logic [2:0] rv,
                          output logic [31:0] yv, output logic nxv, output int lat);
        @(negedge clk);
        bus.valid_input = 1'b1;
        bus.a           = av;
        bus.rm          = rv;
        @(posedge clk);
        #1;
        bus.valid_input = 1'b0;
        lat = 0;
        while (!bus.valid_output && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        yv  = bus.y;
        nxv = bus.nx;
    endtask

    initial begin
        logic [31:0] yv, ye;
        logic        nxv, nxe;
        int          lat, seen, gap;
        logic [31:0] av;
        logic [2:0]  rv;

        n_checks = 0;
        n_errors = 0;
        bus.valid_input = 1'b0;
        bus.a  = '0;
        bus.rm = '0;
        rst_n  = 1'b0;

        vecs.push_back('{32'h00000000, 3'd0, 32'h00000000, 1'b0});
        vecs.push_back('{32'h00000001, 3'd0, 32'h3F800000, 1'b0});
        vecs.push_back('{32'h00FFFFFF, 3'd0, 32'h4B7FFFFF, 1'b0});
        vecs.push_back('{32'h01000001, 3'd0, 32'h4B800000, 1'b1});
        vecs.push_back('{32'h01000001, 3'd3, 32'h4B800001, 1'b1});
        vecs.push_back('{32'h01000001, 3'd1, 32'h4B800000, 1'b1});
        vecs.push_back('{32'h01000003, 3'd0, 32'h4B800002, 1'b1});
        vecs.push_back('{32'h01000003, 3'd4, 32'h4B800002, 1'b1});
        vecs.push_back('{32'hFFFFFFFF, 3'd0, 32'h4F800000, 1'b1});
        vecs.push_back('{32'hFFFFFFFF, 3'd1, 32'h4F7FFFFF, 1'b1});
        vecs.push_back('{32'hFFFFFFFF, 3'd2, 32'h4F7FFFFF, 1'b1});
        vecs.push_back('{32'h01000003, 3'd7, 32'h4B800002, 1'b1});

        repeat (3) @(posedge clk);
        #1;
        check("reset_y", bus.y, 32'h0);
        check("reset_nx", 32'(bus.nx), 32'h0);
        check("reset_busy", 32'(bus.busy), 32'h0);
        check("reset_valid", 32'(bus.valid_output), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            run_op(vecs[i].a, vecs[i].rm, yv, nxv, lat);
            check($sformatf("vec%0d_y", i), yv, vecs[i].y);
            check($sformatf("vec%0d_nx", i), 32'(nxv), 32'(vecs[i].nx));
            check($sformatf("vec%0d_lat", i), 32'(lat), 32'd4);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_pulse_len", i), 32'(bus.valid_output), 32'h0);
        end

        // valid_input pulsed in NORM and ROUND must be ignored
        @(negedge clk);
        bus.valid_input = 1'b1; bus.a = 32'h00000005; bus.rm = 3'd0;
        @(posedge clk); #1;
        bus.valid_input = 1'b0;
        check("busy_after_accept", 32'(bus.busy), 32'h1);
        @(negedge clk);
        bus.valid_input = 1'b1; bus.a = 32'h12345678;
        @(negedge clk);
        bus.valid_input = 1'b1; bus.a = 32'h00000009;
        @(negedge clk);
        bus.valid_input = 1'b0;
        seen = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            if (bus.valid_output) begin
                seen++;
                if (seen == 1) check("ignore_y", bus.y, 32'h40A00000);
            end
        end
        check("ignore_pulses", 32'(seen), 32'd1);

        // reset during ROUND aborts the op
        @(negedge clk);
        bus.valid_input = 1'b1; bus.a = 32'h00001234; bus.rm = 3'd0;
        @(posedge clk); #1;
        bus.valid_input = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("abort_y", bus.y, 32'h0);
        check("abort_busy", 32'(bus.busy), 32'h0);
        check("abort_valid", 32'(bus.valid_output), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            if (bus.valid_output) seen++;
        end
        check("abort_no_pulse", 32'(seen), 32'd0);
        run_op(32'h00000003, 3'd0, yv, nxv, lat);
        check("after_abort_y", yv, 32'h40400000);
        check("after_abort_lat", 32'(lat), 32'd4);

        // valid_input held high: back-to-back ops every 5 cycles
        @(negedge clk);
        bus.valid_input = 1'b1; bus.a = 32'h00000002; bus.rm = 3'd0;
        seen = 0; gap = 0; lat = 0;
        for (int c = 0; c < 20 && seen < 2; c++) begin
            @(posedge clk); #1;
            if (seen == 1) gap++;
            if (bus.valid_output) seen++;
        end
        @(negedge clk);
        bus.valid_input = 1'b0;
        check("held_pulses", 32'(seen), 32'd2);
        check("held_gap", 32'(gap), 32'd5);
        repeat (6) @(posedge clk);

        for (int k = 0; k < 200; k++) begin
            av = $urandom() >> $urandom_range(0, 31);
            rv = 3'($urandom_range(0, 7));
            run_op(av, rv, yv, nxv, lat);
            ref_model(av, rv, ye, nxe);
            check($sformatf("rand%0d_y a=%08h rm=%0d", k, av, rv), yv, ye);
            check($sformatf("rand%0d_nx", k), 32'(nxv), 32'(nxe));
            if (lat != 4) check($sformatf("rand%0d_lat", k), 32'(lat), 32'd4);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
